lsu_subword: RTL and testbench

- Load/store unit between the pipeline MEM stage and the word-only data memory.
- Turns MIPS byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.
- Flags misaligned, out-of-range and illegal-size requests as faults; no memory access is made for those.
- Data memory is little-endian with a combinational read port.

---
 rtl/lsu_subword.sv | 167 ++++++++++++++++
 tb/tb_lsu_subword.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Byte/half/word load-store unit over a word-only, little-endian memory; sub-word stores do read-modify-write.
// Latency: fault 1, load/word store 2, sub-word store 3 cycles; req_ready low while busy, no response backpressure.
module lsu_subword #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    state_e                  state_q;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic [1:0]              lane_q;
    logic [15:0]             wdata_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [31:0]             mem_wdata_q;
    logic                    resp_valid_q;
    logic                    resp_fault_q;
    logic [31:0]             resp_rdata_q;

    logic                    fault_d;
    logic [31:0]             merged_d;
    logic [31:0]             load_d;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_addr   = {{(32-DEPTH_LOG2){1'b0}}, idx_q};

    always_comb begin
        fault_d = 1'b0;
        if (req_size == SZ_ILL)                             fault_d = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])             fault_d = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)  fault_d = 1'b1;
        if ((req_addr >> (DEPTH_LOG2 + 2)) != 32'd0)        fault_d = 1'b1;
    end

    // Read-modify-write merge: splice the store data into the word just read.
    always_comb begin
        merged_d = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (lane_q)
                2'd0:    merged_d[7:0]   = wdata_q[7:0];
                2'd1:    merged_d[15:8]  = wdata_q[7:0];
                2'd2:    merged_d[23:16] = wdata_q[7:0];
                default: merged_d[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (lane_q[1]) merged_d[31:16] = wdata_q;
            else           merged_d[15:0]  = wdata_q;
        end
    end

    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_d = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            idx_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (fault_d) begin
                            // mem_addr keeps its previous value: faults never touch memory.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (req_we && req_size == SZ_WORD) begin
                            state_q     <= WRITE;
                            idx_q       <= req_addr[DEPTH_LOG2+1:2];
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q    <= READ;
                            idx_q      <= req_addr[DEPTH_LOG2+1:2];
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_read_q <= 1'b0;
                    if (we_q) begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                        mem_wdata_q <= merged_d;
                    end else begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= load_d;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    mem_write_q  <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Directed bench for lsu_subword with a word memory model and hand-computed expected values.
module tb_lsu_subword;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Results of the last transaction
    logic [31:0] r_rdata;
    logic        r_fault;
    int          r_lat;
    int          r_nrd;
    int          r_nwr;
    logic [31:0] r_waddr;
    logic [31:0] r_wdat;

    always #5 clk = ~clk;

    lsu_subword #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
    endtask

    // Issue one request, scramble the inputs after acceptance, and observe until the response.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
        int wait_cnt = 0;
        r_rdata = 'x; r_fault = 1'bx; r_lat = 0; r_nrd = 0; r_nwr = 0;
        r_waddr = 'x; r_wdat = 'x;
        @(negedge clk);
        drive(we, sz, uns, addr, wd);
        while (!req_ready && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (mem_read) r_nrd++;
            if (mem_write) begin
                r_nwr++;
                r_waddr = mem_addr;
                r_wdat  = mem_wdata;
            end
            if (resp_valid) begin
                r_rdata = resp_rdata;
                r_fault = resp_fault;
                r_lat   = cyc;
                break;
            end
        end
    endtask

    task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
        do_req(1'b0, sz, uns, addr, 32'h0);
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_lat"}, r_lat, 2);
        check({tag, "_fault"}, {31'd0, r_fault}, 32'd0);
    endtask

    task automatic fault_chk(input string tag, input logic we, input logic [1:0] sz,
                             input logic [31:0] addr);
        do_req(we, sz, 1'b0, addr, 32'hA5A5A5A5);
        check({tag, "_fault"}, {31'd0, r_fault}, 32'd1);
        check({tag, "_lat"}, r_lat, 1);
        check({tag, "_mem"}, r_nrd + r_nwr, 0);
        check({tag, "_rdata"}, r_rdata, 32'h0);
    endtask

    logic [31:0] exp_q [$];
    int          busy;
    int          accepted;
    int          rd_cnt;
    logic        rdy_s;
    logic        saw_resp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        #12;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_memctl", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw_lat", r_lat, 2);
        check("sw_nwr", r_nwr, 1);
        check("sw_nrd", r_nrd, 0);
        check("sw_addr", r_waddr, 32'd4);
        check("sw_rdata", r_rdata, 32'h0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        load_chk("lw", 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);

        // Byte read-modify-write into lane 3
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000012);
        check("sb_lat", r_lat, 3);
        check("sb_nrd", r_nrd, 1);
        check("sb_nwr", r_nwr, 1);
        check("sb_wdata", r_wdat, 32'h12ADBEEF);
        check("sb_mem", mem[4], 32'h12ADBEEF);

        // Extension cases on 0x12AD80EF
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h12AD80EF);
        load_chk("lb", 2'b00, 1'b0, 32'h10, 32'hFFFFFFEF);
        load_chk("lbu", 2'b00, 1'b1, 32'h10, 32'h000000EF);
        load_chk("lh", 2'b01, 1'b0, 32'h10, 32'hFFFF80EF);
        load_chk("lhu", 2'b01, 1'b1, 32'h12, 32'h000012AD);
        load_chk("lb1", 2'b00, 1'b0, 32'h11, 32'hFFFFFF80);

        // Upper-half store, then sign-extended lane 3 byte
        do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFBEEF);
        check("sh_lat", r_lat, 3);
        check("sh_wdata", r_wdat, 32'hBEEF80EF);
        load_chk("lb3", 2'b00, 1'b0, 32'h13, 32'hFFFFFFBE);

        // Faults leave memory untouched
        fault_chk("f_lw_mis", 1'b0, 2'b10, 32'h12);
        fault_chk("f_sh_mis", 1'b1, 2'b01, 32'h11);
        fault_chk("f_lw_oor", 1'b0, 2'b10, 32'h400);
        fault_chk("f_size", 1'b0, 2'b11, 32'h10);
        fault_chk("f_sw_size", 1'b1, 2'b11, 32'h10);
        check("f_mem", mem[4], 32'hBEEF80EF);

        // Reset during the WRITE cycle of a byte store
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 32'h10, 32'h00000055);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_wr_pre", {31'd0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_drop", {31'd0, mem_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("rst_mid_noresp", {31'd0, saw_resp}, 32'd0);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check("rst_mid_mem", mem[4], 32'hBEEF80EF);

        // Continuous req_valid with three queued loads
        exp_q = '{32'hBEEF80EF, 32'h00000080, 32'h0000BEEF};
        busy = 0; accepted = 0; rd_cnt = 0;
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
            @(negedge clk);
            case (accepted)
                0: drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
                1: drive(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
                2: drive(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
                default: req_valid = 1'b0;
            endcase
            rdy_s = req_ready;
            if (!rdy_s) busy++;
            if (mem_read) rd_cnt++;
            if (resp_valid) check($sformatf("hs_resp%0d", 3 - exp_q.size()), resp_rdata, exp_q.pop_front());
            if (exp_q.size() == 0) break;
            @(posedge clk);
            if (rdy_s && req_valid) accepted++;
        end
        req_valid = 1'b0;
        check("hs_done", exp_q.size(), 0);
        check("hs_accepted", accepted, 3);
        check("hs_reads", rd_cnt, 3);
        check("hs_busy", busy, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
